// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART blocks.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_mode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK_WAIT
  } rx_state_e;

  localparam int UART_DEFAULT_DATA_BITS = 8;

  // The reserved encoding 2'b11 behaves as "no parity".
  function automatic parity_mode_e decode_parity(input logic [1:0] mode);
    case (mode)
      2'b01:   return PAR_EVEN;
      2'b10:   return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period tick generator: half-period load on request, then ticks every clk_div+1 cycles.
module uart_baud_tick #(
  parameter int CLK_DIV_WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [CLK_DIV_WIDTH-1:0] clk_div,
  input  logic                     load_half,
  output logic                     tick
);

  logic [CLK_DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic                     at_zero;

  assign at_zero = (cnt_q == '0);
  assign tick    = at_zero && !load_half;

  always_comb begin
    cnt_d = cnt_q - CLK_DIV_WIDTH'(1);
    if (load_half) begin
      cnt_d = clk_div >> 1;
    end else if (at_zero) begin
      cnt_d = clk_div;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: majority-voted sampling, runtime frame format,
// parity/framing/break detection and a single-entry valid/ready holding register.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_DIV_WIDTH = 10,
  parameter int MAX_DATA_BITS = 9,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [CLK_DIV_WIDTH-1:0]           clk_div,
  input  logic [$clog2(MAX_DATA_BITS+1)-1:0] data_bits,
  input  logic [1:0]                         parity_mode,
  input  logic                               two_stop,
  input  logic                               uart_rx_data,
  output logic                               rx_valid,
  input  logic                               rx_ready,
  output logic [MAX_DATA_BITS-1:0]           rx_data,
  output logic                               rx_parity_err,
  output logic                               rx_frame_err,
  output logic                               overrun_err,
  output logic                               break_det,
  output logic                               busy
);

  localparam int DBW = $clog2(MAX_DATA_BITS + 1);

  function automatic logic [DBW-1:0] eff_bits(input logic [DBW-1:0] b);
    if (int'(b) >= 5 && int'(b) <= MAX_DATA_BITS) return b;
    return DBW'(UART_DEFAULT_DATA_BITS);
  endfunction

  logic [SYNC_STAGES-1:0]   sync_q;
  logic [2:0]               hist_q;
  logic                     maj, start_det, tick, load_half, commit, frm_now;

  rx_state_e                state_q, state_d;
  logic [DBW-1:0]           bitcnt_q, bitcnt_d, nbits_q, nbits_d;
  parity_mode_e             par_q, par_d;
  logic                     two_stop_q, two_stop_d, stop2_q, stop2_d;
  logic [MAX_DATA_BITS-1:0] shift_q, shift_d;
  logic                     par_bit_q, par_bit_d, par_err_q, par_err_d;
  logic                     frm_err_q, frm_err_d;

  logic                     rx_valid_q, rx_valid_d, rx_perr_q, rx_perr_d;
  logic                     rx_ferr_q, rx_ferr_d, overrun_q, overrun_d;
  logic                     break_q, break_d;
  logic [MAX_DATA_BITS-1:0] rx_data_q, rx_data_d;

  // Newest synchronised sample sits in hist_q[0].
  assign maj       = (hist_q[2] & hist_q[1]) | (hist_q[1] & hist_q[0]) | (hist_q[2] & hist_q[0]);
  assign start_det = hist_q[1] & ~hist_q[0];

  uart_baud_tick #(
    .CLK_DIV_WIDTH (CLK_DIV_WIDTH)
  ) u_baud (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_div   (clk_div),
    .load_half (load_half),
    .tick      (tick)
  );

  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    nbits_d    = nbits_q;
    par_d      = par_q;
    two_stop_d = two_stop_q;
    stop2_d    = stop2_q;
    shift_d    = shift_q;
    par_bit_d  = par_bit_q;
    par_err_d  = par_err_q;
    frm_err_d  = frm_err_q;
    load_half  = 1'b0;
    commit     = 1'b0;
    frm_now    = frm_err_q;
    break_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_det) begin
          load_half  = 1'b1;
          state_d    = S_START;
          nbits_d    = eff_bits(data_bits);
          par_d      = decode_parity(parity_mode);
          two_stop_d = two_stop;
          stop2_d    = 1'b0;
          shift_d    = '0;
          bitcnt_d   = '0;
          par_bit_d  = 1'b0;
          par_err_d  = 1'b0;
          frm_err_d  = 1'b0;
        end
      end
      S_START: begin
        if (tick) state_d = maj ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (tick) begin
          shift_d[bitcnt_q] = maj;
          bitcnt_d          = bitcnt_q + DBW'(1);
          if (bitcnt_q == nbits_q - DBW'(1)) begin
            state_d = (par_q != PAR_NONE) ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          // Unused upper bits of shift_q are zero, so a full-width XOR is exact.
          par_bit_d = maj;
          par_err_d = (maj != ((par_q == PAR_ODD) ? ~^shift_q : ^shift_q));
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (!stop2_q && !maj && (shift_q == '0) && !par_bit_q) begin
            break_d = 1'b1;
            state_d = S_BREAK_WAIT;
          end else begin
            frm_now   = frm_err_q | ~maj;
            frm_err_d = frm_now;
            if (two_stop_q && !stop2_q) begin
              stop2_d = 1'b1;
            end else begin
              commit  = 1'b1;
              state_d = S_IDLE;
            end
          end
        end
      end
      S_BREAK_WAIT: begin
        if (maj) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    rx_perr_d  = rx_perr_q;
    rx_ferr_d  = rx_ferr_q;
    overrun_d  = 1'b0;
    if (commit) begin
      if (!rx_valid_q || rx_ready) begin
        rx_valid_d = 1'b1;
        rx_data_d  = shift_q;
        rx_perr_d  = par_err_q;
        rx_ferr_d  = frm_now;
      end else begin
        overrun_d  = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '1;
      hist_q     <= 3'b111;
      state_q    <= S_IDLE;
      bitcnt_q   <= '0;
      nbits_q    <= '0;
      par_q      <= PAR_NONE;
      two_stop_q <= 1'b0;
      stop2_q    <= 1'b0;
      shift_q    <= '0;
      par_bit_q  <= 1'b0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
      overrun_q  <= 1'b0;
      break_q    <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], uart_rx_data};
      hist_q     <= {hist_q[1:0], sync_q[SYNC_STAGES-1]};
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      nbits_q    <= nbits_d;
      par_q      <= par_d;
      two_stop_q <= two_stop_d;
      stop2_q    <= stop2_d;
      shift_q    <= shift_d;
      par_bit_q  <= par_bit_d;
      par_err_q  <= par_err_d;
      frm_err_q  <= frm_err_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      rx_perr_q  <= rx_perr_d;
      rx_ferr_q  <= rx_ferr_d;
      overrun_q  <= overrun_d;
      break_q    <= break_d;
    end
  end

  assign rx_valid      = rx_valid_q;
  assign rx_data       = rx_data_q;
  assign rx_parity_err = rx_perr_q;
  assign rx_frame_err  = rx_ferr_q;
  assign overrun_err   = overrun_q;
  assign break_det     = break_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: table-driven frames, randomized frames against a frame-level model,
// and hand-written glitch, break, overrun and reset sequences.
module tb_uart_rx_cfg;

  localparam int CDW = 10;
  localparam int MDB = 9;
  localparam int SS  = 2;
  localparam int DBW = $clog2(MDB + 1);

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [CDW-1:0] clk_div = 10'd15;
  logic [DBW-1:0] data_bits = 4'd8;
  logic [1:0]     parity_mode = 2'd0;
  logic           two_stop = 1'b0;
  logic           uart_rx_data = 1'b1;
  logic           rx_ready = 1'b1;
  logic           rx_valid;
  logic [MDB-1:0] rx_data;
  logic           rx_parity_err, rx_frame_err, overrun_err, break_det, busy;

  uart_rx_cfg #(
    .CLK_DIV_WIDTH (CDW),
    .MAX_DATA_BITS (MDB),
    .SYNC_STAGES   (SS)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clk_div       (clk_div),
    .data_bits     (data_bits),
    .parity_mode   (parity_mode),
    .two_stop      (two_stop),
    .uart_rx_data  (uart_rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .rx_data       (rx_data),
    .rx_parity_err (rx_parity_err),
    .rx_frame_err  (rx_frame_err),
    .overrun_err   (overrun_err),
    .break_det     (break_det),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0] w;
    logic       pe;
    logic       fe;
  } word_t;

  typedef struct {
    int         cd;
    int         dbits;
    int         pm;
    bit         two;
    logic [8:0] d;
    int         nb;
    bit         haspar;
    logic       pbit;
    logic       s2;
    logic [8:0] ew;
    logic       ep;
    logic       ef;
  } vec_t;

  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    frame_t0 = 0;
  int    brk_cnt = 0;
  int    ovr_cnt = 0;
  int    rise_cyc = -1;
  logic  prev_v = 1'b0;
  word_t got[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (break_det) brk_cnt <= brk_cnt + 1;
    if (overrun_err) ovr_cnt <= ovr_cnt + 1;
    if (rx_valid && !prev_v) rise_cyc <= cyc;
    prev_v <= rx_valid;
    if (rx_valid && rx_ready) got.push_back({rx_data, rx_parity_err, rx_frame_err});
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: time limit reached, got=timeout want=finish");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input int cd, input logic [8:0] d, input int nb, input bit haspar,
                            input logic pbit, input logic s1, input logic s2, input bit two,
                            input int gl);
    logic fb[$];
    fb.push_back(1'b0);
    for (int i = 0; i < nb; i++) fb.push_back(d[i]);
    if (haspar) fb.push_back(pbit);
    fb.push_back(s1);
    if (two) fb.push_back(s2);
    frame_t0 = cyc;
    foreach (fb[i]) begin
      for (int c = 0; c < cd + 1; c++) begin
        uart_rx_data = (i == gl && c == (cd + 1) / 2) ? ~fb[i] : fb[i];
        tick(1);
      end
    end
    uart_rx_data = 1'b1;
  endtask

  // Cycles from the pin's falling start edge to rx_valid being visible.
  function automatic int latency(input int cd, input int nbits_on_line);
    return (SS + 1) + ((cd >> 1) + 1) + (nbits_on_line - 1) * (cd + 1) + 1;
  endfunction

  function automatic void model(input int db, input int pm, input logic [8:0] d, input logic pb,
                                input logic s2, input bit two,
                                output int nb, output bit hp, output word_t e);
    int   ones;
    logic want;
    nb   = (db >= 5 && db <= 9) ? db : 8;
    hp   = (pm == 1 || pm == 2);
    e.w  = 9'(int'(d) & ((1 << nb) - 1));
    ones = $countones(e.w);
    want = (pm == 1) ? (ones % 2 == 1) : (ones % 2 == 0);
    e.pe = hp && (pb != want);
    e.fe = two && !s2;
  endfunction

  task automatic set_cfg(input int cd, input int db, input int pm, input bit two);
    clk_div     = CDW'(cd);
    data_bits   = DBW'(db);
    parity_mode = 2'(pm);
    two_stop    = two;
  endtask

  task automatic expect_one(input string nm, input int n0, input word_t e);
    check({nm, "_count"}, 32'(got.size() - n0), 32'd1);
    if (got.size() > n0) begin
      check({nm, "_data"}, 32'(got[n0].w), 32'(e.w));
      check({nm, "_perr"}, 32'(got[n0].pe), 32'(e.pe));
      check({nm, "_ferr"}, 32'(got[n0].fe), 32'(e.fe));
    end
  endtask

  vec_t vecs[8];

  initial begin
    int    n0, b0, o0, cd, db, pm, nb, lat;
    bit    two, hp;
    logic [8:0] d;
    logic  pb, s2;
    word_t e;

    vecs[0] = '{15, 8, 0, 1'b0, 9'h0A5, 8, 1'b0, 1'b0, 1'b1, 9'h0A5, 1'b0, 1'b0};
    vecs[1] = '{15, 9, 1, 1'b0, 9'h1C3, 9, 1'b1, 1'b0, 1'b1, 9'h1C3, 1'b1, 1'b0};
    vecs[2] = '{15, 9, 2, 1'b0, 9'h1C3, 9, 1'b1, 1'b0, 1'b1, 9'h1C3, 1'b0, 1'b0};
    vecs[3] = '{15, 7, 0, 1'b1, 9'h05A, 7, 1'b0, 1'b0, 1'b0, 9'h05A, 1'b0, 1'b1};
    vecs[4] = '{10, 4, 0, 1'b0, 9'h081, 8, 1'b0, 1'b0, 1'b1, 9'h081, 1'b0, 1'b0};
    vecs[5] = '{7,  5, 3, 1'b0, 9'h013, 5, 1'b0, 1'b0, 1'b1, 9'h013, 1'b0, 1'b0};
    vecs[6] = '{3,  8, 1, 1'b0, 9'h03C, 8, 1'b1, 1'b0, 1'b1, 9'h03C, 1'b0, 1'b0};
    vecs[7] = '{20, 6, 1, 1'b1, 9'h02B, 6, 1'b1, 1'b1, 1'b1, 9'h02B, 1'b1, 1'b0};

    // Reset state
    tick(3);
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_data", 32'(rx_data), 32'd0);
    check("rst_flags", 32'({rx_parity_err, rx_frame_err, overrun_err, break_det}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick(4);

    // Table-driven frames
    for (int v = 0; v < 8; v++) begin
      set_cfg(vecs[v].cd, vecs[v].dbits, vecs[v].pm, vecs[v].two);
      n0 = got.size();
      send_frame(vecs[v].cd, vecs[v].d, vecs[v].nb, vecs[v].haspar, vecs[v].pbit, 1'b1,
                 vecs[v].s2, vecs[v].two, -1);
      tick(2 * (vecs[v].cd + 1));
      e = '{w: vecs[v].ew, pe: vecs[v].ep, fe: vecs[v].ef};
      expect_one($sformatf("vec%0d", v), n0, e);
      lat = latency(vecs[v].cd, 2 + vecs[v].nb + int'(vecs[v].haspar) + int'(vecs[v].two));
      check($sformatf("vec%0d_latency", v), 32'(rise_cyc - frame_t0), 32'(lat));
    end

    // Randomized frames against the frame-level model
    for (int k = 0; k < 16; k++) begin
      cd  = $urandom_range(24, 3);
      db  = $urandom_range(15, 0);
      pm  = $urandom_range(3, 0);
      two = 1'($urandom_range(1, 0));
      d   = 9'($urandom);
      pb  = 1'($urandom);
      s2  = 1'($urandom);
      model(db, pm, d, pb, s2, two, nb, hp, e);
      set_cfg(cd, db, pm, two);
      n0 = got.size();
      send_frame(cd, d, nb, hp, pb, 1'b1, s2, two, -1);
      tick(2 * (cd + 1));
      expect_one($sformatf("rnd%0d", k), n0, e);
    end

    // False start: 4-cycle low glitch
    set_cfg(15, 8, 0, 1'b0);
    n0 = got.size();
    uart_rx_data = 1'b0;
    tick(4);
    uart_rx_data = 1'b1;
    check("glitch_busy", 32'(busy), 32'd1);
    tick(48);
    check("glitch_novalid", 32'(got.size() - n0), 32'd0);
    check("glitch_idle", 32'(busy), 32'd0);

    // Single-cycle glitch in the middle of a data bit
    n0 = got.size();
    send_frame(15, 9'h055, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1);
    tick(32);
    expect_one("midglitch", n0, '{w: 9'h055, pe: 1'b0, fe: 1'b0});

    // Break: line low for 20 bit periods
    n0 = got.size();
    b0 = brk_cnt;
    uart_rx_data = 1'b0;
    tick(20 * 16);
    uart_rx_data = 1'b1;
    tick(48);
    check("break_pulses", 32'(brk_cnt - b0), 32'd1);
    check("break_novalid", 32'(got.size() - n0), 32'd0);
    check("break_idle", 32'(busy), 32'd0);
    n0 = got.size();
    send_frame(15, 9'h03C, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1);
    tick(32);
    expect_one("after_break", n0, '{w: 9'h03C, pe: 1'b0, fe: 1'b0});

    // Overrun with consumer stalled, then commit coinciding with accept
    rx_ready = 1'b0;
    o0 = ovr_cnt;
    send_frame(15, 9'h011, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1);
    tick(32);
    check("hold_valid", 32'(rx_valid), 32'd1);
    check("hold_data", 32'(rx_data), 32'h011);
    send_frame(15, 9'h022, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1);
    tick(32);
    check("ovr_data_kept", 32'(rx_data), 32'h011);
    check("ovr_pulses", 32'(ovr_cnt - o0), 32'd1);
    n0 = got.size();
    fork
      send_frame(15, 9'h033, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1);
      begin
        tick(latency(15, 10) - 1);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
      end
    join
    tick(8);
    check("same_cycle_data", 32'(rx_data), 32'h033);
    check("same_cycle_valid", 32'(rx_valid), 32'd1);
    check("same_cycle_noovr", 32'(ovr_cnt - o0), 32'd1);
    check("same_cycle_old_taken", 32'(got.size() - n0), 32'd1);
    if (got.size() > n0) check("same_cycle_old_word", 32'(got[n0].w), 32'h011);
    rx_ready = 1'b1;
    tick(1);
    check("accept_valid_fall", 32'(rx_valid), 32'd0);

    // Reset in the middle of a frame while a word is held
    rx_ready = 1'b0;
    send_frame(15, 9'h044, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1);
    tick(32);
    check("pre_reset_valid", 32'(rx_valid), 32'd1);
    n0 = got.size();
    fork
      send_frame(15, 9'h066, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1);
      begin
        tick(80);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(rx_valid), 32'd0);
        check("midrst_data", 32'(rx_data), 32'd0);
        check("midrst_flags", 32'({rx_parity_err, rx_frame_err, overrun_err, break_det}), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
      end
    join
    tick(2);
    rst_n = 1'b1;
    rx_ready = 1'b1;
    tick(48);
    check("postrst_valid", 32'(rx_valid), 32'd0);
    check("postrst_idle", 32'(busy), 32'd0);
    check("postrst_nothing", 32'(got.size() - n0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
